// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM burst path: sequencer state encoding,
// default burst/FIFO geometry and the 16-bit word-address type.
package sdram_pkg;

    localparam int BURST_LEN_DEF  = 256;
    localparam int FIFO_DEPTH_DEF = 1024;

    typedef logic [15:0] addr_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CHK  = 3'd1,
        WR_REQ  = 3'd2,
        WR_WAIT = 3'd3,
        RD_CHK  = 3'd4,
        RD_REQ  = 3'd5,
        RD_WAIT = 3'd6,
        HOLD    = 3'd7
    } state_t;

    // Start address of the following burst. The extra bit keeps a step past
    // 16'hFFFF visible so the range terminates instead of wrapping to 0.
    function automatic logic [16:0] next_burst_addr(input logic [16:0] cur, input int bl);
        return cur + 17'(bl);
    endfunction

endpackage

// File: rtl/sdram_burst_seq_if.sv
// Burst request/acknowledge channel between the burst sequencer (master)
// and the SDRAM command layer (slave).
interface sdram_burst_seq_if;
    import sdram_pkg::*;

    logic  burst_req;   // request pending, held until acknowledged
    logic  burst_wr;    // 1 write, 0 read; valid with burst_req
    addr_t burst_addr;  // burst start word address; valid with burst_req
    logic  burst_ack;   // command layer takes the request this cycle
    logic  burst_done;  // one-cycle pulse when the accepted burst finishes

    modport master (
        output burst_req, burst_wr, burst_addr,
        input  burst_ack, burst_done
    );

    modport slave (
        input  burst_req, burst_wr, burst_addr,
        output burst_ack, burst_done
    );

endinterface

// File: rtl/sdram_burst_seq.sv
// Splits an inclusive word-address range into fixed-length SDRAM bursts,
// pacing each burst on FIFO level (data present for writes, room for reads).
// A finished range parks in HOLD until its start level drops, so a start
// that stays high does not restart the same range.
module sdram_burst_seq
    import sdram_pkg::*;
#(
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             start_wr_i,
    input  logic             start_rd_i,
    input  addr_t            wraddr_begin_i,
    input  addr_t            wraddr_end_i,
    input  addr_t            rdaddr_begin_i,
    input  addr_t            rdaddr_end_i,
    input  logic [CNT_W-1:0] wfifo_cnt_i,
    input  logic [CNT_W-1:0] rfifo_cnt_i,
    output logic             flag_wr_o,
    output logic             flag_rd_o,
    output logic             err_o,
    sdram_burst_seq_if.master bus
);

    state_t      state_q;
    logic [16:0] cur_addr_q;    // 17 bits so a step past the top is seen
    addr_t       end_addr_q;
    logic        hold_wr_q;     // which start input HOLD is waiting on
    logic        flag_wr_q;
    logic        flag_rd_q;
    logic        burst_req_q;
    logic        burst_wr_q;
    addr_t       burst_addr_q;
    logic        err_q;

    logic [16:0] addr_next_d;
    logic        past_end;
    logic        next_past_end;
    logic        wr_ready;
    logic        rd_ready;
    logic        in_wait;

    // Address step and level compares used by the FSM below
    always_comb begin
        addr_next_d   = next_burst_addr(cur_addr_q, BURST_LEN);
        past_end      = cur_addr_q  > {1'b0, end_addr_q};
        next_past_end = addr_next_d > {1'b0, end_addr_q};
        wr_ready      = int'(wfifo_cnt_i) >= BURST_LEN;
        rd_ready      = (FIFO_DEPTH - int'(rfifo_cnt_i)) >= BURST_LEN;
        in_wait       = (state_q == WR_WAIT) || (state_q == RD_WAIT);
    end

    // Sequencer FSM with registered outputs and sticky protocol error
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            end_addr_q   <= '0;
            hold_wr_q    <= 1'b0;
            flag_wr_q    <= 1'b0;
            flag_rd_q    <= 1'b0;
            burst_req_q  <= 1'b0;
            burst_wr_q   <= 1'b0;
            burst_addr_q <= '0;
            err_q        <= 1'b0;
        end else begin
            // done with no burst outstanding, or ack with nothing requested
            if ((bus.burst_done && !in_wait) || (bus.burst_ack && !burst_req_q))
                err_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (start_wr_i) begin
                        state_q    <= WR_CHK;
                        cur_addr_q <= {1'b0, wraddr_begin_i};
                        end_addr_q <= wraddr_end_i;
                        hold_wr_q  <= 1'b1;
                        flag_wr_q  <= 1'b1;
                    end else if (start_rd_i) begin
                        state_q    <= RD_CHK;
                        cur_addr_q <= {1'b0, rdaddr_begin_i};
                        end_addr_q <= rdaddr_end_i;
                        hold_wr_q  <= 1'b0;
                        flag_rd_q  <= 1'b1;
                    end
                end

                // only reached past the end on an empty range (begin > end)
                WR_CHK: begin
                    if (past_end) begin
                        state_q   <= HOLD;
                        flag_wr_q <= 1'b0;
                    end else if (wr_ready) begin
                        state_q      <= WR_REQ;
                        burst_req_q  <= 1'b1;
                        burst_wr_q   <= 1'b1;
                        burst_addr_q <= cur_addr_q[15:0];
                    end
                end

                WR_REQ: begin
                    if (bus.burst_ack) begin
                        state_q     <= WR_WAIT;
                        burst_req_q <= 1'b0;
                    end
                end

                // deciding termination here drops the flag one cycle after
                // the final done rather than after an extra CHK pass
                WR_WAIT: begin
                    if (bus.burst_done) begin
                        cur_addr_q <= addr_next_d;
                        if (next_past_end) begin
                            state_q   <= HOLD;
                            flag_wr_q <= 1'b0;
                        end else begin
                            state_q <= WR_CHK;
                        end
                    end
                end

                RD_CHK: begin
                    if (past_end) begin
                        state_q   <= HOLD;
                        flag_rd_q <= 1'b0;
                    end else if (rd_ready) begin
                        state_q      <= RD_REQ;
                        burst_req_q  <= 1'b1;
                        burst_wr_q   <= 1'b0;
                        burst_addr_q <= cur_addr_q[15:0];
                    end
                end

                RD_REQ: begin
                    if (bus.burst_ack) begin
                        state_q     <= RD_WAIT;
                        burst_req_q <= 1'b0;
                    end
                end

                RD_WAIT: begin
                    if (bus.burst_done) begin
                        cur_addr_q <= addr_next_d;
                        if (next_past_end) begin
                            state_q   <= HOLD;
                            flag_rd_q <= 1'b0;
                        end else begin
                            state_q <= RD_CHK;
                        end
                    end
                end

                HOLD: begin
                    if (hold_wr_q ? !start_wr_i : !start_rd_i)
                        state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign flag_wr_o      = flag_wr_q;
    assign flag_rd_o      = flag_rd_q;
    assign err_o          = err_q;
    assign bus.burst_req  = burst_req_q;
    assign bus.burst_wr   = burst_wr_q;
    assign bus.burst_addr = burst_addr_q;

endmodule

// File: tb/tb_sdram_burst_seq.sv
// Bench for sdram_burst_seq: directed scenarios plus randomized ranges with
// random ack/done latency, checked against a range-stepping reference list.
module tb_sdram_burst_seq;
    import sdram_pkg::*;

    localparam int BL    = 256;
    localparam int DEPTH = 1024;
    localparam int CW    = 11;

    logic          clk = 1'b0;
    logic          nRST = 1'b0;
    logic          start_wr = 1'b0, start_rd = 1'b0;
    addr_t         wb = '0, we = '0, rb = '0, re = '0;
    logic [CW-1:0] wcnt = '0, rcnt = '0;
    logic          flag_wr, flag_rd, err;

    sdram_burst_seq_if bus();

    sdram_burst_seq #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk            (clk),
        .nRST           (nRST),
        .start_wr_i     (start_wr),
        .start_rd_i     (start_rd),
        .wraddr_begin_i (wb),
        .wraddr_end_i   (we),
        .rdaddr_begin_i (rb),
        .rdaddr_end_i   (re),
        .wfifo_cnt_i    (wcnt),
        .rfifo_cnt_i    (rcnt),
        .flag_wr_o      (flag_wr),
        .flag_rd_o      (flag_rd),
        .err_o          (err),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    addr_t got_addr[$];
    logic  got_wr[$];
    addr_t exp_addr[$];

    typedef struct {
        int flag_cycles;  // cycles the serviced flag was seen high
        int fall_lag;     // cycles from last done to flag low, -1 if none
        int proto_bad;    // req unstable before ack, or req still high after ack
        bit other_flag;   // opposite flag seen high during the transfer
        bit post_other;   // opposite flag high right after start drops
        bit retrig;       // activity while start held high after completion
        bit to;           // cycle budget expired
    } xres_t;

    // Reference: every BL-step from begin that does not exceed end (none if begin > end)
    task automatic build_model(input addr_t b, input addr_t e);
        exp_addr.delete();
        for (int a = int'(b); a <= int'(e); a += BL)
            exp_addr.push_back(addr_t'(a));
    endtask

    // Command-layer responder: runs one range, records accepted bursts
    task automatic run_xfer(input bit wr, input addr_t b, input addr_t e,
                            input int max_dly, input int hold_extra, output xres_t r);
        int    cyc = 0, dly, done_dly = 0, last_done = -1, fall = -1;
        bit    seen = 0, pend = 0, fl, req_seen = 0;
        addr_t req_addr = '0;
        logic  req_wr = 1'b0;
        r = '{default: 0};
        got_addr.delete();
        got_wr.delete();
        if (wr) begin wb = b; we = e; start_wr = 1'b1; end
        else    begin rb = b; re = e; start_rd = 1'b1; end
        dly = int'($urandom_range(max_dly, 0));
        forever begin
            @(negedge clk);
            cyc++;
            bus.burst_ack  = 1'b0;
            bus.burst_done = 1'b0;
            fl = wr ? flag_wr : flag_rd;
            if (wr ? flag_rd : flag_wr) r.other_flag = 1;
            if (fl) begin
                seen = 1;
                r.flag_cycles++;
            end else if (seen) begin
                fall = cyc;
                break;
            end
            if (pend) begin
                if (bus.burst_req) r.proto_bad++;
                if (done_dly == 0) begin
                    bus.burst_done = 1'b1;
                    pend = 0;
                    last_done = cyc;
                end else done_dly--;
            end else if (bus.burst_req) begin
                if (!req_seen) begin
                    req_seen = 1;
                    req_addr = bus.burst_addr;
                    req_wr   = bus.burst_wr;
                end else if (bus.burst_addr !== req_addr || bus.burst_wr !== req_wr)
                    r.proto_bad++;
                if (dly == 0) begin
                    bus.burst_ack = 1'b1;
                    got_addr.push_back(bus.burst_addr);
                    got_wr.push_back(bus.burst_wr);
                    pend = 1;
                    req_seen = 0;
                    done_dly = int'($urandom_range(max_dly, 0));
                    dly = int'($urandom_range(max_dly, 0));
                end else dly--;
            end
            if (cyc > 5000) begin r.to = 1; break; end
        end
        bus.burst_ack  = 1'b0;
        bus.burst_done = 1'b0;
        for (int i = 0; i < hold_extra; i++) begin
            @(negedge clk);
            if (bus.burst_req || (wr ? flag_wr : flag_rd)) r.retrig = 1;
        end
        if (wr) start_wr = 1'b0; else start_rd = 1'b0;
        @(negedge clk);
        r.post_other = wr ? flag_rd : flag_wr;
        r.fall_lag = (last_done < 0) ? -1 : fall - last_done;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.burst_ack = 1'b0;
        bus.burst_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({flag_wr, flag_rd, bus.burst_req, bus.burst_wr, bus.burst_addr, err} !== 21'b0) begin
            failures++;
            $display("FAIL reset_outputs: got fw=%b fr=%b req=%b wr=%b addr=%h err=%b, need all 0",
                     flag_wr, flag_rd, bus.burst_req, bus.burst_wr, bus.burst_addr, err);
        end
        nRST = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        xres_t r;
        wcnt = 11'd512;
        rcnt = 11'd0;
        run_xfer(1'b1, 16'h0000, 16'h03FF, 0, 0, r);
        build_model(16'h0000, 16'h03FF);
        checks++;
        if (r.to || got_addr.size() != 4) begin
            failures++;
            $display("FAIL wr_basic_count: got %0d bursts (timeout=%0b), need 4", got_addr.size(), r.to);
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_wr[i] !== 1'b1) begin
                failures++;
                $display("FAIL wr_basic_burst%0d: got addr=%h wr=%b, need addr=%h wr=1",
                         i, got_addr[i], got_wr[i], exp_addr[i]);
            end
        end
        checks++;
        if (r.fall_lag !== 1 || r.proto_bad !== 0 || err !== 1'b0) begin
            failures++;
            $display("FAIL wr_basic_flag: got fall_lag=%0d proto_bad=%0d err=%b, need 1/0/0",
                     r.fall_lag, r.proto_bad, err);
        end
    endtask

    task automatic test_read_throttle();
        bit early = 0;
        int w = 0;
        rb = 16'h0100;
        re = 16'h0100;
        rcnt = 11'd800;
        start_rd = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.burst_req) early = 1;
        end
        checks++;
        if (early || flag_rd !== 1'b1) begin
            failures++;
            $display("FAIL rd_throttle_wait: got early_req=%0b flag_rd=%b, need 0/1", early, flag_rd);
        end
        rcnt = 11'd768;
        while (!bus.burst_req && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (bus.burst_req !== 1'b1 || bus.burst_addr !== 16'h0100 || bus.burst_wr !== 1'b0) begin
            failures++;
            $display("FAIL rd_throttle_req: got req=%b addr=%h wr=%b, need 1/0100/0",
                     bus.burst_req, bus.burst_addr, bus.burst_wr);
        end
        bus.burst_ack = 1'b1;
        @(negedge clk);
        bus.burst_ack = 1'b0;
        checks++;
        if (bus.burst_req !== 1'b0) begin
            failures++;
            $display("FAIL rd_req_drop: got req=%b after ack, need 0", bus.burst_req);
        end
        bus.burst_done = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        checks++;
        if (flag_rd !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL rd_flag_fall: got flag_rd=%b err=%b, need 0/0", flag_rd, err);
        end
        start_rd = 1'b0;
        rcnt = 11'd0;
        @(negedge clk);
    endtask

    task automatic test_empty_range();
        xres_t r;
        wcnt = 11'd1023;
        run_xfer(1'b1, 16'h0200, 16'h0100, 0, 4, r);
        checks++;
        if (r.to || got_addr.size() != 0 || r.flag_cycles !== 1 || r.retrig !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL empty_range: got bursts=%0d flag_cycles=%0d retrig=%0b err=%b, need 0/1/0/0",
                     got_addr.size(), r.flag_cycles, r.retrig, err);
        end
    endtask

    task automatic test_top_of_mem();
        xres_t r;
        wcnt = 11'd512;
        run_xfer(1'b1, 16'hFE00, 16'hFFFF, 2, 2, r);
        checks++;
        if (r.to || got_addr.size() != 2) begin
            failures++;
            $display("FAIL top_count: got %0d bursts, need 2", got_addr.size());
        end else begin
            checks++;
            if (got_addr[0] !== 16'hFE00 || got_addr[1] !== 16'hFF00) begin
                failures++;
                $display("FAIL top_addrs: got %h,%h, need FE00,FF00", got_addr[0], got_addr[1]);
            end
        end
        checks++;
        if (r.fall_lag !== 1 || r.retrig !== 1'b0) begin
            failures++;
            $display("FAIL top_flag: got fall_lag=%0d retrig=%0b, need 1/0", r.fall_lag, r.retrig);
        end
    endtask

    task automatic test_back_to_back();
        xres_t r;
        wcnt = 11'd512;
        rcnt = 11'd0;
        rb = 16'h1000;
        re = 16'h11FF;
        start_rd = 1'b1;
        run_xfer(1'b1, 16'h0000, 16'h01FF, 1, 3, r);
        checks++;
        if (r.to || got_addr.size() != 2 || got_wr[0] !== 1'b1 || r.other_flag || r.retrig || r.post_other) begin
            failures++;
            $display("FAIL both_write_first: got bursts=%0d other_flag=%0b retrig=%0b post_rd=%0b, need 2/0/0/0",
                     got_addr.size(), r.other_flag, r.retrig, r.post_other);
        end
        @(negedge clk);
        checks++;
        if (flag_rd !== 1'b1) begin
            failures++;
            $display("FAIL both_read_starts: got flag_rd=%b, need 1", flag_rd);
        end
        run_xfer(1'b0, 16'h1000, 16'h11FF, 1, 0, r);
        checks++;
        if (r.to || got_addr.size() != 2 || r.other_flag) begin
            failures++;
            $display("FAIL both_read_count: got bursts=%0d other_flag=%0b, need 2/0", got_addr.size(), r.other_flag);
        end else begin
            checks++;
            if (got_addr[0] !== 16'h1000 || got_addr[1] !== 16'h1100 || got_wr[0] !== 1'b0 || got_wr[1] !== 1'b0) begin
                failures++;
                $display("FAIL both_read_addrs: got %h/%b %h/%b, need 1000/0 1100/0",
                         got_addr[0], got_wr[0], got_addr[1], got_wr[1]);
            end
        end
    endtask

    task automatic test_err_and_reset();
        int w = 0;
        @(negedge clk);
        bus.burst_done = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_stray_done: got err=%b, need 1", err);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got err=%b, need 1", err);
        end
        nRST = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        bus.burst_ack = 1'b1;
        @(negedge clk);
        bus.burst_ack = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_stray_ack: got err=%b, need 1", err);
        end
        nRST = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        wcnt = 11'd512;
        wb = 16'h0000;
        we = 16'h03FF;
        start_wr = 1'b1;
        while (!bus.burst_req && w < 10) begin
            @(negedge clk);
            w++;
        end
        bus.burst_ack = 1'b1;
        @(negedge clk);
        bus.burst_ack = 1'b0;
        checks++;
        if (flag_wr !== 1'b1 || bus.burst_req !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midwait_setup: got flag_wr=%b req=%b err=%b, need 1/0/0", flag_wr, bus.burst_req, err);
        end
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({flag_wr, flag_rd, bus.burst_req, bus.burst_wr, bus.burst_addr, err} !== 21'b0) begin
            failures++;
            $display("FAIL midwait_reset: got fw=%b fr=%b req=%b wr=%b addr=%h err=%b, need all 0",
                     flag_wr, flag_rd, bus.burst_req, bus.burst_wr, bus.burst_addr, err);
        end
        start_wr = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (flag_wr !== 1'b0 || bus.burst_req !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got flag_wr=%b req=%b err=%b, need 0/0/0", flag_wr, bus.burst_req, err);
        end
    endtask

    task automatic test_random();
        xres_t r;
        bit    wr;
        addr_t b, e;
        int    ei;
        for (int t = 0; t < 10; t++) begin
            wr = bit'($urandom_range(1, 0));
            if ($urandom_range(4, 0) == 0) begin
                b = addr_t'($urandom_range(65535, 1));
                e = addr_t'($urandom_range(int'(b) - 1, 0));
            end else begin
                b = addr_t'($urandom_range(65535, 0));
                ei = int'(b) + int'($urandom_range(1500, 0));
                if (ei > 65535) ei = 65535;
                e = addr_t'(ei);
            end
            wcnt = CW'($urandom_range(1023, 256));
            rcnt = CW'($urandom_range(768, 0));
            run_xfer(wr, b, e, 3, int'($urandom_range(2, 0)), r);
            build_model(b, e);
            checks++;
            if (r.to || got_addr.size() != exp_addr.size()) begin
                failures++;
                $display("FAIL rand%0d_count: range %h..%h got %0d bursts, need %0d",
                         t, b, e, got_addr.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    checks++;
                    if (got_addr[i] !== exp_addr[i] || got_wr[i] !== wr) begin
                        failures++;
                        $display("FAIL rand%0d_burst%0d: got addr=%h wr=%b, need addr=%h wr=%b",
                                 t, i, got_addr[i], got_wr[i], exp_addr[i], wr);
                    end
                end
            end
            checks++;
            if ((exp_addr.size() == 0) ? (r.flag_cycles !== 1) : (r.fall_lag !== 1)) begin
                failures++;
                $display("FAIL rand%0d_flag: got flag_cycles=%0d fall_lag=%0d, bursts expected %0d",
                         t, r.flag_cycles, r.fall_lag, exp_addr.size());
            end
            checks++;
            if (r.proto_bad !== 0 || r.other_flag || r.retrig || err !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_proto: got proto_bad=%0d other_flag=%0b retrig=%0b err=%b, need 0",
                         t, r.proto_bad, r.other_flag, r.retrig, err);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_throttle();
        test_empty_range();
        test_top_of_mem();
        test_back_to_back();
        test_random();
        test_err_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
